// File: rtl/rect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rect_arbiter
// Purpose  : Round-robin arbiter for four requesters that captures the
//            granted requester's two's-complement sample and returns its
//            absolute value over a valid/ready output. It also counts how
//            many negative samples it has captured.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : per-requester request, held until granted
//   in_data    : four packed N-bit samples, requester k on [k*N +: N]
//   out_ready  : downstream accepts the result
//   clr_count  : synchronous clear of neg_count (wins over an increment)
//   gnt[3:0]   : one-hot grant, single-cycle pulse in the grant cycle
//   busy       : high whenever the FSM is not idle
//   out_valid  : result valid
//   out_data   : absolute value of the captured sample
//   out_id     : index of the requester owning out_data
//   out_sat    : result was saturated
//   neg_count  : saturating count of negative samples captured
// Configuration
//   RECT_SAT_EN : when defined, the most-negative input saturates to the
//                 largest positive value and raises out_sat. When undefined,
//                 that input wraps to 2^(N-1) and out_sat is tied low.
// ============================================================================
module rect_arbiter #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] in_data,
    input  logic           out_ready,
    input  logic           clr_count,
    output logic [3:0]     gnt,
    output logic           busy,
    output logic           out_valid,
    output logic [N-1:0]   out_data,
    output logic [1:0]     out_id,
    output logic           out_sat,
    output logic [15:0]    neg_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [N-1:0] c_one      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] c_most_neg = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] c_max_pos  = {1'b0, {(N-1){1'b1}}};
    localparam logic [15:0]  c_cnt_max  = 16'hFFFF;

    state_t       r_state;
    logic [1:0]   r_last_id;
    logic [N-1:0] r_sample;
    logic [1:0]   r_sample_id;

    logic         w_win_vld;
    logic [1:0]   w_win_id;
    logic [1:0]   w_cand;
    logic [N-1:0] w_win_sample;
    logic         w_capture;
    logic [N-1:0] w_abs;
    logic         w_sat;

    // Round-robin search starting just after the last served requester.
    // The fourth candidate wraps back to last_id itself, so it has the
    // lowest priority this round.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = r_last_id;
        w_cand    = r_last_id;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last_id + 2'(i);
            if (!w_win_vld && req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_id  = w_cand;
            end
        end
    end

    assign w_win_sample = in_data[int'(w_win_id)*N +: N];
    assign w_capture    = (r_state == S_IDLE) && w_win_vld;

    // The grant has to be visible in the same cycle the winner is captured
    // (grant at T, result at T+2, next grant at T+3), so it is decoded from
    // the state register rather than registered. rst_n gating keeps it at
    // zero while reset is held, even if requests are already present.
    assign gnt  = (w_capture && rst_n) ? (4'b0001 << w_win_id) : 4'b0000;
    assign busy = (r_state != S_IDLE);

    // Absolute value of the captured sample.
    always_comb begin
        w_abs = r_sample[N-1] ? (~r_sample + c_one) : r_sample;
        w_sat = 1'b0;
`ifdef RECT_SAT_EN
        if (r_sample == c_most_neg) begin
            w_abs = c_max_pos;
            w_sat = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_id   <= 2'd3;
            r_sample    <= '0;
            r_sample_id <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_id      <= 2'd0;
            neg_count   <= 16'd0;
        end else begin
            if (clr_count) begin
                neg_count <= 16'd0;
            end else if (w_capture && w_win_sample[N-1] && (neg_count != c_cnt_max)) begin
                neg_count <= neg_count + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_sample    <= w_win_sample;
                        r_sample_id <= w_win_id;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    out_data  <= w_abs;
                    out_id    <= r_sample_id;
                    out_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_last_id <= out_id;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RECT_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
        end else if (r_state == S_CALC) begin
            out_sat <= w_sat;
        end
    end
`else
    assign out_sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rect_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_arbiter
// Purpose  : Self-checking bench for rect_arbiter. Stimulus pushes expected
//            grants and results into queues; a monitor on the falling edge
//            pops and compares whenever the DUT presents a grant or result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_arbiter;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req = 4'b0000;
    logic [4*N-1:0] in_data = '0;
    logic           out_ready = 1'b0;
    logic           clr_count = 1'b0;
    logic [3:0]     gnt;
    logic           busy;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_sat;
    logic [15:0]    neg_count;

    rect_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .clr_count (clr_count),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_sat   (out_sat),
        .neg_count (neg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   id;
        logic [N-1:0] data;
        logic         sat;
    } res_t;

    res_t       exp_q[$];
    logic [3:0] gnt_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   gnt_seen = 0;
    int   xfer_seen = 0;
    int   stall_cnt = 0;
    int   gnt_cyc = 0;
    bit   chk_period = 1'b0;
    bit   period_armed = 1'b0;
    bit   vld_seen = 1'b0;
    res_t held;

`ifdef RECT_SAT_EN
    localparam logic [N-1:0] MOST_NEG_RES = 16'h7FFF;
    localparam logic         MOST_NEG_SAT = 1'b1;
`else
    localparam logic [N-1:0] MOST_NEG_RES = 16'h8000;
    localparam logic         MOST_NEG_SAT = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id,
                        input logic [N-1:0] d, input logic s);
        res_t r;
        r.id   = id;
        r.data = d;
        r.sat  = s;
        gnt_q.push_back(g);
        exp_q.push_back(r);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: all DUT observations happen on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_seen = 1'b0;
        end else begin
            if (gnt != 4'b0000) begin
                chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
                if (gnt_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL gnt_unexpected: actual=%b required=none", gnt);
                end else begin
                    chk("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
                end
                if (chk_period && period_armed) chk("gnt_period", 32'(cyc - gnt_cyc), 32'd3);
                period_armed = chk_period;
                gnt_cyc = cyc;
                gnt_seen++;
            end
            if (out_valid && !vld_seen) begin
                vld_seen = 1'b1;
                chk("valid_latency", 32'(cyc - gnt_cyc), 32'd2);
                held.id   = out_id;
                held.data = out_data;
                held.sat  = out_sat;
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                chk("stall_data", 32'(out_data), 32'(held.data));
                chk("stall_id", 32'(out_id), 32'(held.id));
                chk("stall_busy", 32'(busy), 32'd1);
                chk("stall_gnt", 32'(gnt), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL result_unexpected: actual id=%0d data=0x%0h required=none",
                             out_id, out_data);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_id", 32'(out_id), 32'(e.id));
                    chk("out_sat", 32'(out_sat), 32'(e.sat));
                end
                vld_seen = 1'b0;
                xfer_seen++;
            end
        end
    end

    // Raise req (and optionally clr_count) until the grant is seen, then drop.
    task automatic issue(input logic [3:0] r, input logic clr);
        int  g0;
        bit  got;
        g0  = gnt_seen;
        got = 1'b0;
        @(posedge clk); #1;
        req       = r;
        clr_count = clr;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (gnt_seen != g0) begin
                got = 1'b1;
                break;
            end
        end
        req       = 4'b0000;
        clr_count = 1'b0;
        if (!got) timeout("grant_wait");
    endtask

    task automatic wait_xfer(input int target);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (xfer_seen >= target) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) timeout("xfer_wait");
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int x0;
        int g0;
        bit got;

        // Reset state, with requests present to show gnt stays low.
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_negcnt", 32'(neg_count), 32'd0);
        req   = 4'b0000;
        rst_n = 1'b1;

        // Single request, slice0 = -5.
        out_ready = 1'b1;
        in_data[15:0] = 16'hFFFB;
        push(4'b0001, 2'd0, 16'd5, 1'b0);
        x0 = xfer_seen;
        issue(4'b0001, 1'b0);
        chk("t1_negcnt", 32'(neg_count), 32'd1);
        wait_xfer(x0 + 1);
        chk("t1_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // All four requesting from reset: order 0,1,2,3,0, one grant per 3 cycles.
        pulse_reset();
        in_data = {16'h7FFF, 16'h0000, 16'hFFFF, 16'h0064};
        push(4'b0001, 2'd0, 16'h0064, 1'b0);
        push(4'b0010, 2'd1, 16'h0001, 1'b0);
        push(4'b0100, 2'd2, 16'h0000, 1'b0);
        push(4'b1000, 2'd3, 16'h7FFF, 1'b0);
        push(4'b0001, 2'd0, 16'h0064, 1'b0);
        x0 = xfer_seen;
        g0 = gnt_seen;
        got = 1'b0;
        chk_period = 1'b1;
        period_armed = 1'b0;
        @(posedge clk); #1;
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (gnt_seen >= g0 + 5) begin
                got = 1'b1;
                break;
            end
        end
        req = 4'b0000;
        chk_period = 1'b0;
        if (!got) timeout("rr_grants");
        wait_xfer(x0 + 5);
        chk("t2_negcnt", 32'(neg_count), 32'd1);

        // Back-pressure: out_ready low for 5 cycles while out_valid is high.
        out_ready = 1'b0;
        in_data[31:16] = 16'h1234;
        push(4'b0010, 2'd1, 16'h1234, 1'b0);
        x0 = xfer_seen;
        stall_cnt = 0;
        issue(4'b0010, 1'b0);
        @(posedge clk); #1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_xfer(x0 + 1);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("t3_valid_drop", 32'(out_valid), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Most-negative input on requester 3.
        in_data[63:48] = 16'h8000;
        push(4'b1000, 2'd3, MOST_NEG_RES, MOST_NEG_SAT);
        x0 = xfer_seen;
        issue(4'b1000, 1'b0);
        chk("t4_negcnt", 32'(neg_count), 32'd2);
        wait_xfer(x0 + 1);

        // Reset while holding a result in OUT: no transfer, outputs cleared.
        out_ready = 1'b0;
        in_data[15:0] = 16'hFFF0;
        push(4'b0001, 2'd0, 16'h0010, 1'b0);
        x0 = xfer_seen;
        issue(4'b0001, 1'b0);
        chk("t5_negcnt", 32'(neg_count), 32'd3);
        @(posedge clk); #1;
        chk("t5_valid_before_rst", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_data", 32'(out_data), 32'd0);
        chk("t5_rst_id", 32'(out_id), 32'd0);
        chk("t5_rst_negcnt", 32'(neg_count), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("t5_no_valid", 32'(out_valid), 32'd0);
        end
        chk("t5_no_xfer", 32'(xfer_seen), 32'(x0));
        in_data[47:32] = 16'h0007;
        push(4'b0100, 2'd2, 16'h0007, 1'b0);
        issue(4'b0100, 1'b0);
        wait_xfer(x0 + 1);

        // neg_count saturation and clear-over-increment.
        @(posedge clk); #1;
        force dut.neg_count = 16'hFFFF;
        #1;
        release dut.neg_count;
        in_data[15:0] = 16'hFFFF;
        push(4'b0001, 2'd0, 16'h0001, 1'b0);
        x0 = xfer_seen;
        issue(4'b0001, 1'b0);
        chk("t6_negcnt_sat", 32'(neg_count), 32'hFFFF);
        wait_xfer(x0 + 1);
        push(4'b0001, 2'd0, 16'h0001, 1'b0);
        issue(4'b0001, 1'b1);
        chk("t6_clr_wins", 32'(neg_count), 32'd0);
        wait_xfer(x0 + 2);
        push(4'b0001, 2'd0, 16'h0001, 1'b0);
        issue(4'b0001, 1'b0);
        chk("t6_count_after_clr", 32'(neg_count), 32'd1);
        wait_xfer(x0 + 3);

        chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        chk("res_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rect_arbiter.md
RECT_ARBITER -- requirements
Module: rect_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning sample width in bits (two's complement).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req  input  4  per-requester service request, held by requester until granted.
REQ-005 The block SHALL have port in_data  input  4*N  packed samples, requester k on bits [k*N+N-1:k*N].
REQ-006 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-007 The block SHALL have port clr_count  input  1  synchronous clear of neg_count.
REQ-008 The block SHALL have port gnt  output  4  one-hot grant, single-cycle pulse.
REQ-009 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_data  output  N  rectified (absolute) value.
REQ-012 The block SHALL have port out_id  output  2  index of requester owning out_data.
REQ-013 The block SHALL have port out_sat  output  1  result was saturated.
REQ-014 The block SHALL have port neg_count  output  16  count of negative samples captured.

Function
REQ-015 The FSM SHALL have states IDLE, CALC, OUT; the state encoding is unconstrained.
REQ-016 In IDLE with any req bit high, the block SHALL pick a winner by round-robin starting at last_id+1 mod 4, pulse gnt for that cycle, capture its in_data slice, and move to CALC.
REQ-017 In IDLE with req==0, the block SHALL stay in IDLE with gnt==0.
REQ-018 In CALC, the block SHALL register the absolute value of the captured sample: bit N-1 clear -> unchanged; bit N-1 set -> two's complement negate. It SHALL then assert out_valid and move to OUT.
REQ-019 In OUT, out_valid, out_data, out_id and out_sat SHALL be held stable until out_ready is high.
REQ-020 On the cycle out_valid and out_ready are both high, the transfer SHALL complete: out_valid deasserts next cycle, last_id becomes out_id, and the FSM returns to IDLE.
REQ-021 Minimum latency SHALL be: grant in cycle T, out_valid in cycle T+2, next grant no earlier than T+3.
REQ-022 A req bit dropped before it is granted SHALL NOT be served; req changes while busy SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set.
REQ-024 neg_count SHALL increment on each capture whose sample bit N-1 is set, and SHALL saturate at 0xFFFF.
REQ-025 clr_count SHALL zero neg_count; if clr_count coincides with an increment, the clear SHALL win and the result SHALL be 0.

Reset
REQ-026 While rst_n is low, state SHALL be IDLE, gnt=0, busy=0, out_valid=0, out_data=0, out_id=0, out_sat=0, neg_count=0, and last_id=3, so that requester 0 has first priority.
REQ-027 Reset asserted mid-transaction SHALL discard the pending result without any out_valid pulse.

Configuration
REQ-028 With macro RECT_SAT_EN defined, the most-negative input (1 followed by N-1 zeros) SHALL produce out_data = 2^(N-1)-1 (0x7FFF for N=16) with out_sat=1.
REQ-029 Without RECT_SAT_EN, that input SHALL produce out_data = 2^(N-1) (0x8000, wrap), and out_sat SHALL be tied to 0.

Verification
REQ-030 req=0001, slice0=-5, out_ready=1 -> gnt=0001 in cycle T, out_valid=1 in T+2 with out_data=5 and out_id=0, neg_count=1.
REQ-031 req=1111 held, out_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-032 out_ready=0 for 5 cycles with out_valid high -> out_data and out_id remain stable, busy=1, gnt=0 throughout; transfer completes on the first cycle out_ready=1.
REQ-033 Input 0x8000 (N=16) -> 0x7FFF with out_sat=1 under RECT_SAT_EN; 0x8000 with out_sat=0 without it.
REQ-034 rst_n pulsed low during OUT -> all outputs 0 immediately, no transfer; the next req=0100 is granted to requester 2.
REQ-035 neg_count at 0xFFFF plus a negative capture -> stays 0xFFFF; clr_count coincident with an increment -> 0.
